spi_target: RTL and testbench

SPI mode-0 target (responder) and the far end of the team's FIFO-fed SPI initiator.
- Oversamples scsn/sclk/mosi in the local clk domain.
- Deserializes MOSI bytes, MSB first, into a write FIFO.
- Serializes bytes from a first-word-fall-through read FIFO onto miso.
- Used as the flash/peripheral model in system benches and as a real target port.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_target_if.sv | 36 +++
 rtl/spi_sync.sv | 59 +++++
 rtl/spi_target.sv | 187 ++++++++++++++++++
 tb/tb_spi_target.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target slice.
// Contents:
//   spi_state_t       - frame sequencer states (ST_IDLE, ST_LOAD, ST_SHIFT)
//   SPI_DATA_DEFAULT  - default SPI word / FIFO width
//   SPI_FILL_DEFAULT  - default byte sent when the read FIFO is empty
//   SPI_CPOL/SPI_CPHA - SPI mode this block implements (mode 0)
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam int         SPI_DATA_DEFAULT = 8;
    localparam logic [7:0] SPI_FILL_DEFAULT = 8'h00;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_target_if.sv
// Bus bundle between an SPI target and its surroundings: the serial pins
// plus the write-FIFO and FWFT read-FIFO handshakes.
// Signals:
//   scsn, sclk, mosi - serial inputs from the initiator
//   miso             - serial output to the initiator
//   wdata, wr, full  - write FIFO data, push strobe, full flag
//   rdata, rd, empty - read FIFO head, pop strobe, empty flag
// Modports: slave (the target's view), master (pins/FIFO side view).
interface spi_target_if
    import spi_pkg::*;
#(
    parameter int DATA = SPI_DATA_DEFAULT
) ();

    logic            scsn;
    logic            sclk;
    logic            mosi;
    logic            miso;
    logic [DATA-1:0] wdata;
    logic            wr;
    logic            full;
    logic [DATA-1:0] rdata;
    logic            rd;
    logic            empty;

    modport slave (
        input  scsn, sclk, mosi, full, rdata, empty,
        output miso, wdata, wr, rd
    );

    modport master (
        output scsn, sclk, mosi, full, rdata, empty,
        input  miso, wdata, wr, rd
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with optional edge
// detection from one extra delay flop behind the synchronized level.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   d        - asynchronous input
//   level    - synchronized level (STAGES clk cycles of latency)
//   rise     - one-cycle pulse when level goes 0 -> 1 (0 if EDGES=0)
//   fall     - one-cycle pulse when level goes 1 -> 0 (0 if EDGES=0)
module spi_sync #(
    parameter int STAGES = 2,
    parameter bit EDGES  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] chain;

    // Clear to 0 on reset: a chip select that is already low when reset
    // releases then never produces a falling edge, so a frame in flight is
    // ignored until the next real select.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign level = chain[DEPTH-1];

    generate
        if (EDGES) begin : g_edges
            logic delay_q;

            // One more flop behind the synchronized level gives the edge pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    delay_q <= 1'b0;
                end else begin
                    delay_q <= level;
                end
            end

            assign rise = level & ~delay_q;
            assign fall = ~level & delay_q;
        end else begin : g_level_only
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples scsn/sclk/mosi in the clk domain, pushes
// received words (MSB first) into a write FIFO and streams words popped from
// a first-word-fall-through read FIFO onto miso.
// Optional feature macro: SPI_TARGET_ECHO_EN adds an 'echo' input; when it is
// high at chip-select the frame echoes the last received word instead of
// reading the FIFO.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   bus         - spi_target_if.slave (serial pins + FIFO handshakes)
//   echo        - (SPI_TARGET_ECHO_EN only) echo mode request
//   busy        - frame in progress
//   byte_count  - words completed in the current/last frame, saturating
//   ovf         - sticky: a received word was dropped because FIFO full
//   unf         - sticky: FILL was sent because read FIFO empty
module spi_target
    import spi_pkg::*;
#(
    parameter int              DATA        = SPI_DATA_DEFAULT,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA-1:0] FILL        = DATA'(SPI_FILL_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    spi_target_if.slave       bus,
`ifdef SPI_TARGET_ECHO_EN
    input  logic              echo,
`endif
    output logic              busy,
    output logic [15:0]       byte_count,
    output logic              ovf,
    output logic              unf
);

    localparam int CW = (DATA > 2) ? $clog2(DATA) : 1;

    spi_state_t      state;
    logic [CW-1:0]   bit_cnt;
    logic [DATA-1:0] tx_shift;
    logic [DATA-2:0] rx_shift;
    logic [DATA-1:0] rx_next;
    logic [DATA-1:0] load_byte;
    logic            load_pop;
    logic            load_unf;

    logic sclk_rise, sclk_fall, cs_start, cs_end, mosi_s;
    logic sclk_level_unused, scsn_level_unused;
    logic mosi_rise_unused, mosi_fall_unused;

`ifdef SPI_TARGET_ECHO_EN
    logic echo_q;
    logic have_rx;
`endif

    spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(bus.sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_scsn (
        .clk(clk), .rst(rst), .d(bus.scsn),
        .level(scsn_level_unused), .rise(cs_end), .fall(cs_start)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(bus.mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign rx_next  = {rx_shift, mosi_s};
    assign bus.miso = (state == ST_SHIFT) && tx_shift[DATA-1];

    // Source of the next transmit word: the FIFO head when data is there,
    // otherwise FILL with the underflow flag. In echo mode the last word
    // received in this frame is sent back and the FIFO is left alone.
    always_comb begin
        load_byte = FILL;
        load_pop  = 1'b0;
        load_unf  = 1'b0;
`ifdef SPI_TARGET_ECHO_EN
        if (echo_q) begin
            load_byte = have_rx ? bus.wdata : FILL;
        end else
`endif
        if (!bus.empty) begin
            load_byte = bus.rdata;
            load_pop  = 1'b1;
        end else begin
            load_unf  = 1'b1;
        end
    end

    // Frame sequencer. Chip-select release wins over any sclk edge seen in
    // the same cycle, which drops a partial word and any word already
    // reloaded for transmit. Data is captured on synchronized sclk rises and
    // miso advances on synchronized falls; a fall at a word boundary fetches
    // the next transmit word instead of shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bus.wdata  <= '0;
            bus.wr     <= 1'b0;
            bus.rd     <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
`ifdef SPI_TARGET_ECHO_EN
            echo_q     <= 1'b0;
            have_rx    <= 1'b0;
`endif
        end else begin
            bus.wr <= 1'b0;
            bus.rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (cs_start) begin
                        byte_count <= '0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
`ifdef SPI_TARGET_ECHO_EN
                        echo_q     <= echo;
                        have_rx    <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (cs_end) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tx_shift <= load_byte;
                        bus.rd   <= load_pop;
                        if (load_unf) begin
                            unf <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_end) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[DATA-2:0];
                        if (bit_cnt == CW'(DATA - 1)) begin
                            bit_cnt   <= '0;
                            bus.wdata <= rx_next;
                            if (!bus.full) begin
                                bus.wr <= 1'b1;
                            end else begin
                                ovf <= 1'b1;
                            end
                            if (byte_count != 16'hFFFF) begin
                                byte_count <= byte_count + 16'd1;
                            end
`ifdef SPI_TARGET_ECHO_EN
                            have_rx <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            tx_shift <= load_byte;
                            bus.rd   <= load_pop;
                            if (load_unf) begin
                                unf <= 1'b1;
                            end
                        end else begin
                            tx_shift <= {tx_shift[DATA-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a table of directed frames, two
// hand-written corner sequences (abort, reset mid-frame) and randomized
// frames checked against a frame-level reference model.
module tb_spi_target;
    import spi_pkg::*;

    localparam int         SYNC   = 2;
    localparam int         HALF   = 8;
    localparam logic [7:0] FILL_B = SPI_FILL_DEFAULT;

    typedef struct packed {
        int             n;
        logic [3:0][7:0] mosi;
        int             nfifo;
        logic [3:0][7:0] fifo;
        logic [3:0]     full_mask;
        int             exp_nwr;
        logic [3:0][7:0] exp_w;
        logic [3:0][7:0] exp_miso;
        int             exp_nrd;
        logic [15:0]    exp_cnt;
        logic           exp_ovf;
        logic           exp_unf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] byte_count;
    logic        ovf;
    logic        unf;

    logic [7:0] fifo_q[$];
    logic [7:0] wr_q[$];
    int         rd_count = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    vec_t vecs[4];

    spi_target_if #(.DATA(8)) bus ();

    spi_target #(.DATA(8), .SYNC_STAGES(SYNC), .FILL(FILL_B)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
`ifdef SPI_TARGET_ECHO_EN
        .echo(1'b0),
`endif
        .busy(busy),
        .byte_count(byte_count),
        .ovf(ovf),
        .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model and strobe monitor: pops the read FIFO on rd, records every
    // written word, and presents the FWFT head (garbage when empty).
    always @(negedge clk) begin
        if (bus.wr === 1'b1) begin
            wr_q.push_back(bus.wdata);
        end
        if (bus.rd === 1'b1) begin
            rd_count <= rd_count + 1;
            if (fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
            end
        end
        bus.rdata <= (fifo_q.size() > 0) ? fifo_q[0] : 8'hEE;
        bus.empty <= (fifo_q.size() == 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".miso"}, 32'(bus.miso), 32'd0);
        checkOutput({tag, ".wdata"}, 32'(bus.wdata), 32'd0);
        checkOutput({tag, ".wr"}, 32'(bus.wr), 32'd0);
        checkOutput({tag, ".rd"}, 32'(bus.rd), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".byte_count"}, 32'(byte_count), 32'd0);
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'd0);
        checkOutput({tag, ".unf"}, 32'(unf), 32'd0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        bus.scsn = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.full = 1'b0;
        fifo_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        repeat (4) @(negedge clk);
    endtask

    // One SPI bit as a mode-0 initiator: data set with sclk low, miso
    // sampled just before the rising edge. Leaves sclk high.
    task automatic driveBit(input logic b, output logic s);
        bus.mosi = b;
        repeat (HALF) @(negedge clk);
        s = bus.miso;
        bus.sclk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Whole frame of n words; the final sclk fall and scsn release happen
    // together, so no word is fetched past the end of the frame.
    task automatic applyStimulus(input int n, input logic [3:0][7:0] data,
                                 input logic [3:0] mask,
                                 output logic [3:0][7:0] got);
        logic s;
        got = '0;
        @(negedge clk);
        bus.scsn = 1'b0;
        for (int b = 0; b < n; b++) begin
            bus.full = mask[b];
            for (int k = 7; k >= 0; k--) begin
                driveBit(data[b][k], s);
                got[b][k] = s;
                bus.sclk = 1'b0;
            end
        end
        bus.scsn = 1'b1;
        repeat (12) @(negedge clk);
        bus.full = 1'b0;
    endtask

    task automatic verifyFrame(input string tag, input int n, input int exp_nwr,
                               input logic [3:0][7:0] exp_w,
                               input logic [3:0][7:0] exp_miso,
                               input int exp_nrd, input logic [15:0] exp_cnt,
                               input logic exp_ovf, input logic exp_unf,
                               input logic [3:0][7:0] got, input int rd_base);
        checkOutput({tag, ".nwr"}, 32'(wr_q.size()), 32'(exp_nwr));
        for (int i = 0; i < exp_nwr; i++) begin
            if (i < wr_q.size()) begin
                checkOutput({tag, ".wdata"}, 32'(wr_q[i]), 32'(exp_w[i]));
            end
        end
        for (int b = 0; b < n; b++) begin
            checkOutput({tag, ".miso"}, 32'(got[b]), 32'(exp_miso[b]));
        end
        checkOutput({tag, ".nrd"}, 32'(rd_count - rd_base), 32'(exp_nrd));
        checkOutput({tag, ".byte_count"}, 32'(byte_count), 32'(exp_cnt));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({tag, ".unf"}, 32'(unf), 32'(exp_unf));
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0][7:0] got;
        logic [3:0][7:0] rmosi, rfifo, rexp_w, rexp_miso;
        logic [3:0]      rmask;
        logic            s, model_ovf, model_unf;
        int              rd_base, waited, rn, rnfifo, rnwr;

        rst = 1'b1;
        bus.scsn = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.full = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("por");

        vecs[0] = '{n: 1, mosi: 32'h000000A5, nfifo: 1, fifo: 32'h0000003C,
                    full_mask: 4'b0000, exp_nwr: 1, exp_w: 32'h000000A5,
                    exp_miso: 32'h0000003C, exp_nrd: 1, exp_cnt: 16'd1,
                    exp_ovf: 1'b0, exp_unf: 1'b0};
        vecs[1] = '{n: 4, mosi: 32'h04030201, nfifo: 4, fifo: 32'h40302010,
                    full_mask: 4'b0000, exp_nwr: 4, exp_w: 32'h04030201,
                    exp_miso: 32'h40302010, exp_nrd: 4, exp_cnt: 16'd4,
                    exp_ovf: 1'b0, exp_unf: 1'b0};
        vecs[2] = '{n: 2, mosi: 32'h00007EC3, nfifo: 0, fifo: 32'h00000000,
                    full_mask: 4'b0000, exp_nwr: 2, exp_w: 32'h00007EC3,
                    exp_miso: 32'h00000000, exp_nrd: 0, exp_cnt: 16'd2,
                    exp_ovf: 1'b0, exp_unf: 1'b1};
        vecs[3] = '{n: 3, mosi: 32'h00332211, nfifo: 3, fifo: 32'h00CCBBAA,
                    full_mask: 4'b0010, exp_nwr: 2, exp_w: 32'h00003311,
                    exp_miso: 32'h00CCBBAA, exp_nrd: 3, exp_cnt: 16'd3,
                    exp_ovf: 1'b1, exp_unf: 1'b0};

        for (int v = 0; v < 4; v++) begin
            resetDut();
            for (int i = 0; i < vecs[v].nfifo; i++) begin
                fifo_q.push_back(vecs[v].fifo[i]);
            end
            rd_base = rd_count;
            applyStimulus(vecs[v].n, vecs[v].mosi, vecs[v].full_mask, got);
            verifyFrame($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_nwr,
                        vecs[v].exp_w, vecs[v].exp_miso, vecs[v].exp_nrd,
                        vecs[v].exp_cnt, vecs[v].exp_ovf, vecs[v].exp_unf,
                        got, rd_base);
        end

        // Abort after 5 bits of 8'hFF, straight after a 3-word frame.
        wr_q.delete();
        @(negedge clk);
        bus.scsn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            driveBit(1'b1, s);
            if (k < 4) begin
                bus.sclk = 1'b0;
            end
        end
        checkOutput("abort.busy_mid", 32'(busy), 32'd1);
        bus.sclk = 1'b0;
        bus.scsn = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < SYNC + 2) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort.busy_clear", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("abort.nwr", 32'(wr_q.size()), 32'd0);
        checkOutput("abort.byte_count", 32'(byte_count), 32'd0);

        // Reset pulsed after 3 bits; the rest of that frame must be ignored.
        resetDut();
        fifo_q.push_back(8'h77);
        @(negedge clk);
        bus.scsn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            driveBit(k[0] ? 1'b0 : 1'b1, s);
            bus.sclk = 1'b0;
        end
        checkOutput("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("midrst");
        rst = 1'b0;
        wr_q.delete();
        rd_base = rd_count;
        for (int k = 0; k < 5; k++) begin
            driveBit(1'b1, s);
            bus.sclk = 1'b0;
        end
        checkOutput("midrst.busy_ignored", 32'(busy), 32'd0);
        bus.scsn = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midrst.nwr", 32'(wr_q.size()), 32'd0);
        checkOutput("midrst.nrd", 32'(rd_count - rd_base), 32'd0);
        fifo_q.delete();
        fifo_q.push_back(8'hC6);
        rd_base = rd_count;
        applyStimulus(1, 32'h0000005A, 4'b0000, got);
        verifyFrame("after_rst", 1, 1, 32'h0000005A, 32'h000000C6, 1, 16'd1,
                    1'b0, 1'b0, got, rd_base);

        // Randomized frames; flags accumulate across frames like the DUT's.
        resetDut();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rn     = int'($urandom_range(1, 4));
            rnfifo = int'($urandom_range(0, rn));
            rmask  = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                rmosi[b] = 8'($urandom_range(0, 255));
                rfifo[b] = 8'($urandom_range(0, 255));
            end
            rexp_w    = '0;
            rexp_miso = '0;
            rnwr      = 0;
            for (int b = 0; b < rn; b++) begin
                if (rmask[b]) begin
                    model_ovf = 1'b1;
                end else begin
                    rexp_w[rnwr] = rmosi[b];
                    rnwr++;
                end
                if (b < rnfifo) begin
                    rexp_miso[b] = rfifo[b];
                end else begin
                    rexp_miso[b] = FILL_B;
                    model_unf = 1'b1;
                end
            end
            wr_q.delete();
            fifo_q.delete();
            for (int i = 0; i < rnfifo; i++) begin
                fifo_q.push_back(rfifo[i]);
            end
            rd_base = rd_count;
            applyStimulus(rn, rmosi, rmask, got);
            verifyFrame($sformatf("rand%0d", r), rn, rnwr, rexp_w, rexp_miso,
                        (rn < rnfifo) ? rn : rnfifo, 16'(rn), model_ovf,
                        model_unf, got, rd_base);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
